// File: rtl/spart_pkg.sv
// Shared SPART constants: transmitter FSM encoding, parity modes and register map.
package spart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam logic [1:0] ADDR_TXBUF = 2'b00;

   // Mode 2'b11 is treated as "no parity", same as PAR_NONE.
   function automatic logic parity_on(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/find_rising_edge.sv
// Registered rising-edge detector: one-cycle pulse per low-to-high transition of sig.
module find_rising_edge (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic sig_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sig_q <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sig_q <= sig;
         rise  <= sig & ~sig_q;
      end
   end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// SPART transmitter with write FIFO, selectable parity and stop bits, paced by the baud-enable ticks.
module uart_tx_fifo
   import spart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int OVERSAMPLE = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tx_en,
   input  logic                          iocs,
   input  logic                          iorw,
   input  logic [1:0]                    ioaddr,
   input  logic [DATA_BITS-1:0]          transmit_buffer,
   input  logic [1:0]                    parity_mode,
   input  logic                          two_stop,
   output logic                          txd,
   output logic                          tbr,
   output logic                          tx_idle,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [2:0]                    dbg_state
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   logic                 tick;
   logic                 wr;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_dout;
   logic [DATA_BITS-1:0] shift;
   logic [2:0]           state;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_idx;
   logic                 par_en;
   logic                 par_val;
   logic                 stop2;
   logic                 stop_idx;
   logic                 bit_end;
   logic                 stop_last;
   logic                 line;

   assign wr        = iocs & ~iorw & (ioaddr == ADDR_TXBUF);
   assign bit_end   = tick & (tick_cnt == TICK_LAST);
   assign stop_last = (state == ST_STOP) & (~stop2 | stop_idx);
   // Reload straight from the last stop bit so consecutive frames have no idle gap.
   assign pop       = ~fifo_empty & ((state == ST_IDLE) | (stop_last & bit_end));

   find_rising_edge u_tick (
      .clk  (clk),
      .rst  (rst),
      .sig  (tx_en),
      .rise (tick)
   );

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr),
      .pop   (pop),
      .din   (transmit_buffer),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      line = 1'b1;
      case (state)
         ST_START:  line = 1'b0;
         ST_DATA:   line = shift[0];
         ST_PARITY: line = par_val;
         default:   line = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         tick_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         par_en   <= 1'b0;
         par_val  <= 1'b0;
         stop2    <= 1'b0;
         stop_idx <= 1'b0;
         txd      <= 1'b1;
         overflow <= 1'b0;
      end else begin
         overflow <= wr & fifo_full & ~pop;
         txd      <= line;
         // Frame format is captured here so later config writes only affect the next frame.
         if (pop) begin
            shift    <= fifo_dout;
            par_en   <= parity_on(parity_mode);
            par_val  <= (^fifo_dout) ^ (parity_mode == PAR_ODD);
            stop2    <= two_stop;
            stop_idx <= 1'b0;
            tick_cnt <= '0;
            state    <= ST_START;
         end else if ((state != ST_IDLE) && tick) begin
            if (tick_cnt != TICK_LAST) begin
               tick_cnt <= tick_cnt + TW'(1);
            end else begin
               tick_cnt <= '0;
               case (state)
                  ST_START: begin
                     bit_idx <= '0;
                     state   <= ST_DATA;
                  end
                  ST_DATA: begin
                     shift <= shift >> 1;
                     if (bit_idx == BIT_LAST) begin
                        stop_idx <= 1'b0;
                        state    <= par_en ? ST_PARITY : ST_STOP;
                     end else begin
                        bit_idx <= bit_idx + BW'(1);
                     end
                  end
                  ST_PARITY: begin
                     stop_idx <= 1'b0;
                     state    <= ST_STOP;
                  end
                  ST_STOP: begin
                     if (stop2 && !stop_idx) stop_idx <= 1'b1;
                     else                    state    <= ST_IDLE;
                  end
                  default: state <= ST_IDLE;
               endcase
            end
         end
      end
   end

   assign tbr       = ~fifo_full;
   assign tx_idle   = (state == ST_IDLE) & fifo_empty;
   assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed/randomized bench for uart_tx_fifo: a line-level UART receiver model decodes txd
// against an expected-frame queue; FIFO status is predicted from plain occupancy arithmetic.
module tb_uart_tx_fifo;

   localparam int OS = 16;

   logic       clk;
   logic       rst;
   logic       tx_en;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic [7:0] transmit_buffer;
   logic [1:0] parity_mode;
   logic       two_stop;
   logic       txd;
   logic       tbr;
   logic       tx_idle;
   logic [2:0] fifo_count;
   logic       overflow;
   logic [2:0] dbg_state;

   uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .OVERSAMPLE(OS)) dut (
      .clk             (clk),
      .rst             (rst),
      .tx_en           (tx_en),
      .iocs            (iocs),
      .iorw            (iorw),
      .ioaddr          (ioaddr),
      .transmit_buffer (transmit_buffer),
      .parity_mode     (parity_mode),
      .two_stop        (two_stop),
      .txd             (txd),
      .tbr             (tbr),
      .tx_idle         (tx_idle),
      .fifo_count      (fifo_count),
      .overflow        (overflow),
      .dbg_state       (dbg_state)
   );

   // ---------------- clock / tick source ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   int tick_period = 2;
   int tick_ph = 0;
   always @(negedge clk) begin
      tick_ph = (tick_ph + 1 >= tick_period) ? 0 : tick_ph + 1;
      tx_en   = (tick_ph == 0);
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [10:0] exp_q[$];          // {two_stop, parity_mode, data}
   int fall_q[$];
   int frames_rx = 0;
   int model_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int frame_bits(input logic [1:0] pm, input logic ts);
      return 10 + (((pm == 2'b01) || (pm == 2'b10)) ? 1 : 0) + (ts ? 1 : 0);
   endfunction

   // ---------------- line receiver model ----------------
   logic        mon_kill = 1'b0;
   logic        rx_active = 1'b0;
   int          rx_next, rx_k, rx_nbits, rx_b;
   logic [11:0] rx_bits;
   logic [10:0] rx_cur;
   logic        rx_pe;

   always @(negedge clk) begin
      if (mon_kill) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (txd === 1'b0) begin
            fall_q.push_back(cyc);
            check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
            rx_cur    = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h000;
            rx_pe     = (rx_cur[9:8] == 2'b01) || (rx_cur[9:8] == 2'b10);
            rx_nbits  = frame_bits(rx_cur[9:8], rx_cur[10]);
            rx_b      = OS * tick_period;
            rx_next   = cyc + rx_b / 2;
            rx_k      = 0;
            rx_bits   = '0;
            rx_active = 1'b1;
         end
      end else if (cyc == rx_next) begin
         rx_bits[rx_k] = txd;
         rx_k++;
         rx_next += rx_b;
         if (rx_k == rx_nbits) begin
            rx_active = 1'b0;
            check("start_bit", 32'(rx_bits[0]), 32'd0);
            check("data_bits", 32'(rx_bits[8:1]), 32'(rx_cur[7:0]));
            if (rx_pe)
               check("parity_bit", 32'(rx_bits[9]), 32'((^rx_cur[7:0]) ^ (rx_cur[9:8] == 2'b10)));
            check("stop_bit1", 32'(rx_bits[rx_pe ? 10 : 9]), 32'd1);
            if (rx_cur[10]) check("stop_bit2", 32'(rx_bits[rx_pe ? 11 : 10]), 32'd1);
            frames_rx++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_write(input logic [7:0] d);
      iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; transmit_buffer = d;
      @(negedge clk);
      iocs = 1'b0; iorw = 1'b1;
   endtask

   task automatic push_write(input logic [7:0] d);
      exp_q.push_back({two_stop, parity_mode, d});
      model_total++;
      do_write(d);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         done = (tx_idle === 1'b1) && !rx_active && (exp_q.size() == 0);
      end
      check(tag, 32'(done), 32'd1);
   endtask

   task automatic wait_falls(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && fall_q.size() < n; i++) @(negedge clk);
      check(tag, 32'(fall_q.size() >= n), 32'd1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed / random sequence ----------------
   int          base, f1, tgt, nb, model_cnt;
   logic        ok, acc;
   logic [7:0]  d;

   initial begin
      rst = 1'b1; iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00; transmit_buffer = '0;
      parity_mode = 2'b00; two_stop = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_tbr", 32'(tbr), 32'd1);
      check("rst_tx_idle", 32'(tx_idle), 32'd1);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      ok = 1'b1;
      repeat (30) begin
         @(negedge clk);
         ok &= (txd === 1'b1) && (tbr === 1'b1) && (tx_idle === 1'b1) && (fifo_count === 3'd0);
      end
      check("idle_sustained", 32'(ok), 32'd1);

      // Single 8N1 frame, txd low two edges after the write edge.
      tick_period = 2;
      push_write(8'hA5);
      check("wr_count", 32'(fifo_count), 32'd1);
      check("wr_txd_still_high", 32'(txd), 32'd1);
      @(negedge clk);
      check("pop_txd_high", 32'(txd), 32'd1);
      check("pop_count", 32'(fifo_count), 32'd0);
      @(negedge clk);
      check("start_low_2cyc", 32'(txd), 32'd0);
      wait_idle("idle_after_a5", 2000);

      // Parity and stop-bit variants.
      parity_mode = 2'b01; two_stop = 1'b1;
      push_write(8'h07);
      wait_idle("idle_after_even", 2000);
      parity_mode = 2'b10; two_stop = 1'b0;
      push_write(8'h07);
      wait_idle("idle_after_odd", 2000);

      // Fill the FIFO while a frame is in flight, then write on the pop edge.
      parity_mode = 2'b00; two_stop = 1'b0; tick_period = 3;
      repeat (4) @(negedge clk);
      base = fall_q.size();
      push_write(8'($urandom_range(0, 255)));
      repeat (4) @(negedge clk);
      model_cnt = 0;
      for (int k = 1; k <= 5; k++) begin
         d   = 8'($urandom_range(0, 255));
         acc = (model_cnt < 4);
         if (acc) begin
            push_write(d);
            model_cnt++;
         end else begin
            do_write(d);
         end
         check("fill_count", 32'(fifo_count), 32'(model_cnt));
         check("fill_tbr", 32'(tbr), 32'(model_cnt != 4));
         check("fill_overflow", 32'(overflow), 32'(!acc));
      end
      @(negedge clk);
      check("overflow_one_cycle", 32'(overflow), 32'd0);

      wait_falls("fall_b1", base + 2, 3000);
      f1 = fall_q[base + 1];
      push_write(8'($urandom_range(0, 255)));
      check("refill_count", 32'(fifo_count), 32'd4);
      tgt = f1 - 1 + 10 * OS * tick_period;
      while (cyc < tgt - 1) @(negedge clk);
      push_write(8'($urandom_range(0, 255)));
      check("popwr_overflow", 32'(overflow), 32'd0);
      check("popwr_count", 32'(fifo_count), 32'd4);
      check("popwr_tbr", 32'(tbr), 32'd0);
      wait_idle("idle_after_fill", 6000);
      check("gap_b1_b2", 32'(fall_q[base + 2] - fall_q[base + 1]), 32'(10 * OS * tick_period));
      check("gap_b2_b3", 32'(fall_q[base + 3] - fall_q[base + 2]), 32'(10 * OS * tick_period));

      // Config change mid-frame only affects the following frame.
      tick_period = 2; parity_mode = 2'b01; two_stop = 1'b0;
      push_write(8'($urandom_range(0, 255)));
      repeat (3 * OS * 2) @(negedge clk);
      parity_mode = 2'b10;
      push_write(8'($urandom_range(0, 255)));
      wait_idle("idle_after_cfg", 2000);

      // Reset during DATA aborts the frame and empties the FIFO.
      parity_mode = 2'b00;
      push_write(8'($urandom_range(0, 255)));
      push_write(8'($urandom_range(0, 255)));
      repeat (3 * OS * 2) @(negedge clk);
      rst = 1'b0; mon_kill = 1'b1;
      #1;
      check("midrst_txd", 32'(txd), 32'd1);
      check("midrst_count", 32'(fifo_count), 32'd0);
      check("midrst_tx_idle", 32'(tx_idle), 32'd1);
      exp_q.delete();
      model_total -= 2;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      mon_kill = 1'b0;
      check("postrst_txd", 32'(txd), 32'd1);
      push_write(8'($urandom_range(0, 255)));
      wait_idle("idle_after_rst", 2000);

      // Non-transmit accesses must not enqueue.
      for (int i = 0; i < 4; i++) begin
         iocs = 1'b1; iorw = 1'($urandom_range(0, 1));
         ioaddr = iorw ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 3));
         transmit_buffer = 8'($urandom_range(0, 255));
         @(negedge clk);
         iocs = 1'b0; iorw = 1'b1;
         @(negedge clk);
         check("decoy_count", 32'(fifo_count), 32'd0);
         check("decoy_idle", 32'(tx_idle), 32'd1);
      end

      // Random bursts of back-to-back frames.
      for (int b = 0; b < 3; b++) begin
         tick_period = $urandom_range(2, 3);
         parity_mode = 2'($urandom_range(0, 3));
         two_stop    = 1'($urandom_range(0, 1));
         nb   = frame_bits(parity_mode, two_stop);
         repeat (4) @(negedge clk);
         base = fall_q.size();
         for (int k = 0; k < 3; k++) push_write(8'($urandom_range(0, 255)));
         wait_idle("idle_after_burst", 8000);
         check("burst_gap", 32'(fall_q[base + 2] - fall_q[base + 1]), 32'(nb * OS * tick_period));
      end

      check("frames_total", 32'(frames_rx), 32'(model_total));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
